square_motion_ctrl: RTL

// Per-frame motion controller for one rectangular screen object.

---
 rtl/square_motion_ctrl_if.sv | 22 ++
 rtl/square_motion_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl_if.sv
// Frame-control and position bundle between the video pipeline and square_motion_ctrl.
// The master side supplies frame timing and collisions; the slave side returns the object position.
interface square_motion_ctrl_if;
  logic               startOfFrame;
  logic               enable;
  logic               collisionX;
  logic               collisionY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               frameDone;
  logic [7:0]         bounceCount;

  modport master (
    output startOfFrame, enable, collisionX, collisionY,
    input  topLeftX, topLeftY, frameDone, bounceCount
  );

  modport slave (
    input  startOfFrame, enable, collisionX, collisionY,
    output topLeftX, topLeftY, frameDone, bounceCount
  );
endinterface

// File: rtl/square_motion_ctrl.sv
// Per-frame fixed-point motion controller for one rectangle.
// Each accepted startOfFrame runs SPEED -> POS -> CLAMP and then publishes the new top-left corner.
module square_motion_ctrl #(
  parameter int INITIAL_X    = 280,
  parameter int INITIAL_Y    = 185,
  parameter int INIT_SPEED_X = 40,
  parameter int INIT_SPEED_Y = 20,
  parameter int FP_SHIFT     = 6,
  parameter int LEFT_EDGE    = 0,
  parameter int RIGHT_EDGE   = 539,
  parameter int TOP_EDGE     = 0,
  parameter int BOTTOM_EDGE  = 379
) (
  input logic                 clk,
  input logic                 resetN,
  square_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {WAIT_SOF, SPEED, POS, CLAMP} state_t;

  state_t     state_reg, state_next;
  logic [1:0] rev_vec;
  logic [7:0] bounce_reg, bounce_next;
  logic       frame_done_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= WAIT_SOF;
      bounce_reg     <= 8'd0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bounce_reg     <= bounce_next;
      frame_done_reg <= (state_reg == CLAMP);
    end
  end

  always_comb begin
    state_next  = state_reg;
    bounce_next = bounce_reg;
    case (state_reg)
      WAIT_SOF: if (bus.startOfFrame) state_next = SPEED;
      SPEED: begin
        state_next = POS;
        // A frame counts as one bounce however many axes or causes reversed.
        if ((|rev_vec) && (bounce_reg != 8'hFF)) bounce_next = bounce_reg + 8'd1;
      end
      POS:     state_next = CLAMP;
      CLAMP:   state_next = WAIT_SOF;
      default: state_next = WAIT_SOF;
    endcase
  end

  // Axis 0 is X, axis 1 is Y; both follow identical rules with their own edges.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int LO       = (gi == 0) ? LEFT_EDGE    : TOP_EDGE;
      localparam int HI       = (gi == 0) ? RIGHT_EDGE   : BOTTOM_EDGE;
      localparam int INIT_PIX = (gi == 0) ? INITIAL_X    : INITIAL_Y;
      localparam int INIT_SPD = (gi == 0) ? INIT_SPEED_X : INIT_SPEED_Y;
      localparam logic signed [31:0] LO_FP       = 32'(LO) << FP_SHIFT;
      localparam logic signed [31:0] HI_FP       = 32'(HI) << FP_SHIFT;
      localparam logic signed [31:0] INIT_POS_FP = 32'(INIT_PIX) << FP_SHIFT;
      localparam logic signed [31:0] INIT_SPD_FP = 32'(INIT_SPD);
      localparam logic signed [10:0] INIT_TOP    = 11'(INIT_PIX);

      logic signed [31:0] pos_reg, pos_next;
      logic signed [31:0] speed_reg, speed_next;
      logic signed [31:0] pos_clamped;
      logic signed [10:0] top_reg, top_next;
      logic               flag_reg, flag_next;
      logic               coll;
      logic               rev;

      assign coll = (gi == 0) ? bus.collisionX : bus.collisionY;

      always_comb begin
        pos_clamped = pos_reg;
        if (pos_reg < LO_FP)      pos_clamped = LO_FP;
        else if (pos_reg > HI_FP) pos_clamped = HI_FP;

        // Sticky collision and edge contact merge into a single negation.
        rev = bus.enable &&
              (flag_reg ||
               ((pos_reg <= LO_FP) && (speed_reg < 0)) ||
               ((pos_reg >= HI_FP) && (speed_reg > 0)));

        pos_next   = pos_reg;
        speed_next = speed_reg;
        top_next   = top_reg;
        flag_next  = flag_reg;
        case (state_reg)
          SPEED: if (rev) speed_next = -speed_reg;
          POS:   if (bus.enable) pos_next = pos_reg + speed_reg;
          CLAMP: begin
            pos_next  = pos_clamped;
            top_next  = 11'(pos_clamped >>> FP_SHIFT);
            flag_next = 1'b0;
          end
          default: ;
        endcase
        // A collision seen during CLAMP must survive into the next frame.
        if (coll) flag_next = 1'b1;
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          pos_reg   <= INIT_POS_FP;
          speed_reg <= INIT_SPD_FP;
          top_reg   <= INIT_TOP;
          flag_reg  <= 1'b0;
        end else begin
          pos_reg   <= pos_next;
          speed_reg <= speed_next;
          top_reg   <= top_next;
          flag_reg  <= flag_next;
        end
      end

      assign rev_vec[gi] = rev;
    end
  endgenerate

  assign bus.topLeftX    = g_axis[0].top_reg;
  assign bus.topLeftY    = g_axis[1].top_reg;
  assign bus.frameDone   = frame_done_reg;
  assign bus.bounceCount = bounce_reg;

endmodule
